exc_sequencer: RTL and testbench
================================

# exc_sequencer

Multi-cycle controller that sits between the MEM-stage exception priority encoder and CP0/fetch. It takes the single-cycle exception decision (flag, type, bad address, PC), freezes the pipeline, and waits for outstanding memory traffic to drain. It then commits one atomic CP0 update and redirects fetch to the exception vector or ERET target over a valid/ready handshake.

## Interface
Parameters:
- DRAIN_MAX, 255, drain-wait cycles before forced progress (1..255)
- RESET_BASE, 32'hBFC0_0200, vector base when Status.BEV=1
- NORMAL_BASE, 32'h8000_0000, vector base when Status.BEV=0

Ports:
- clk  in  1  clock; all state changes on rising edge
- rst  in  1  synchronous, active-high reset
- exc_flag  in  1  encoder reports an exception this cycle
- exc_type  in  5  encoded type; ExcT codes from core package
- exc_pc  in  32  PC of the faulting instruction
- exc_baddr  in  32  bad virtual address from encoder
- exc_bd  in  1  faulting instruction is in a delay slot
- bus_busy  in  1  I/D memory transactions outstanding
- st_exl, st_erl, st_bev  in  1 each  current CP0 Status bits
- epc, errorepc  in  32  current CP0 values for ERET
- redir_ready  in  1  fetch accepts redirect
- stall  out  1  freeze all pipeline stages
- flush  out  1  kill IF..MEM contents
- cp0_we  out  1  one-cycle CP0 commit strobe
- cp0_epc_we, cp0_bva_we  out  1 each  qualify EPC / BadVAddr write
- cp0_epc, cp0_bva  out  32  values to write
- cp0_exccode  out  5  Cause.ExcCode
- cp0_bd  out  1  Cause.BD
- cp0_set_exl, cp0_clr_exl, cp0_clr_erl  out  1 each  Status updates
- redir_valid  out  1  redirect request
- redir_pc  out  32  redirect target
- drain_tmo  out  1  sticky; a drain hit DRAIN_MAX

## Operation
- FSM states: IDLE, DRAIN, COMMIT, REDIRECT.
- IDLE with exc_flag=1: latch type, pc, baddr and bd. Go to DRAIN.
- DRAIN: 8-bit counter increments each cycle. Leave for COMMIT when bus_busy=0 or counter reaches DRAIN_MAX. A DRAIN_MAX exit sets drain_tmo.
- COMMIT always lasts exactly one cycle and asserts cp0_we.
- COMMIT for ERET:
  - clr_erl=1 if st_erl, else clr_exl=1.
  - Target = errorepc if st_erl, else epc.
  - No EPC or BadVAddr write.
- COMMIT for any other type:
  - set_exl=1.
  - If st_exl=0: EPC write with EPC = bd ? pc−4 : pc, and cp0_bd=bd.
  - If st_exl=1: EPC and BD are not written.
  - cp0_bva_we=1 only for AdE, TLBR, TLBI and TLBM, with cp0_bva = latched baddr.
- Vector computation:
  - Base = st_bev ? RESET_BASE : NORMAL_BASE.
  - Offset = 0x000 for TLBR with st_exl=0, 0x180 for all others.
  - Sum is a 32-bit add; wrap is ignored.
- REDIRECT: redir_valid=1 with redir_pc stable until redir_valid & redir_ready. Then go to IDLE.
- stall = (state≠IDLE). flush = (state≠IDLE) | (IDLE & exc_flag).
- exc_flag outside IDLE is ignored; the pipeline is frozen, so this is a protocol violation. An assertion in the bench checks it never happens.
- drain_tmo clears only on rst.

## Timing
- Reset values:
  - state=IDLE.
  - All outputs 0 except redir_pc.
  - redir_pc=RESET_BASE.
  - drain_counter=0.
  - drain_tmo=0.
- rst asserted in any state returns to IDLE on the next edge. A partial CP0 commit is never emitted.
- Best-case latency, exc_flag at edge T with bus_busy=0:
  - T+1 DRAIN.
  - T+2 COMMIT (cp0_we).
  - T+3 REDIRECT.
  - With redir_ready=1, IDLE at T+4.
- The drain counter resets on DRAIN entry. The cycle count=DRAIN_MAX forces the exit regardless of bus_busy.
- bus_busy falling on the same edge the counter reaches DRAIN_MAX: normal exit, drain_tmo unchanged.
- CP0 outputs are registered and valid only while cp0_we=1. They are 0 otherwise.
- exc_flag in the same cycle the sequencer returns to IDLE is accepted on that edge, giving back-to-back exceptions.

## Structure
- Shared package (core defines) holds:
  - ExcT_* type codes and their 5-bit width.
  - Vector offsets 0x000 / 0x180.
  - FSM state encoding.
- One sub-module, exc_vector_calc: combinational type/BEV/EXL/ERL → target PC and CP0 field values. Unit-testable on its own.
- Single clock domain; no other hierarchy.

## Test plan
- Sys, bus_busy=0, pc=0x8000_1000, BEV=0, EXL=0 → cp0_we at T+2 with EPC=0x8000_1000, set_exl=1. redir_pc=0x8000_0180 at T+3.
- TLBR, bd=1, pc=0x8000_2004, baddr=0x0040_0000, EXL=0 → EPC=0x8000_2000, BD=1, bva=0x0040_0000, redir_pc=0x8000_0000.
- AdE with EXL=1, BEV=1 → cp0_epc_we=0, bva written, redir_pc=0xBFC0_0380.
- ERET with ERL=1, errorepc=0xBFC0_0010 → clr_erl=1, no EPC write, redir_pc=0xBFC0_0010.
- bus_busy held high with DRAIN_MAX=4 → COMMIT after 4 DRAIN cycles, drain_tmo=1 sticky. redir_ready held low 3 cycles → redir_valid/redir_pc stable throughout.
- rst pulsed during REDIRECT → next cycle IDLE, all outputs at reset values, no cp0_we.

Source files
------------

// File: rtl/exc_sequencer_pkg.sv
// Shared core definitions for the exception sequencer: exception type codes,
// vector offsets, FSM encoding and the CP0 update payload.
package exc_sequencer_pkg;

    localparam int unsigned EXCT_W = 5;
    localparam int unsigned XLEN   = 32;
    localparam int unsigned CNT_W  = 8;

    localparam logic [EXCT_W-1:0] EXCT_INT  = 5'd0;
    localparam logic [EXCT_W-1:0] EXCT_TLBM = 5'd1;
    localparam logic [EXCT_W-1:0] EXCT_TLBI = 5'd2;
    localparam logic [EXCT_W-1:0] EXCT_ADE  = 5'd4;
    localparam logic [EXCT_W-1:0] EXCT_SYS  = 5'd8;
    localparam logic [EXCT_W-1:0] EXCT_BP   = 5'd9;
    localparam logic [EXCT_W-1:0] EXCT_RI   = 5'd10;
    localparam logic [EXCT_W-1:0] EXCT_OV   = 5'd12;
    localparam logic [EXCT_W-1:0] EXCT_TLBR = 5'd16;
    localparam logic [EXCT_W-1:0] EXCT_ERET = 5'd17;

    localparam logic [XLEN-1:0] VEC_OFF_REFILL  = 32'h0000_0000;
    localparam logic [XLEN-1:0] VEC_OFF_GENERAL = 32'h0000_0180;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_DRAIN    = 2'd1,
        ST_COMMIT   = 2'd2,
        ST_REDIRECT = 2'd3
    } seq_state_e;

    typedef struct packed {
        logic              epc_we;
        logic              bva_we;
        logic [XLEN-1:0]   epc;
        logic [XLEN-1:0]   bva;
        logic [EXCT_W-1:0] exccode;
        logic              bd;
        logic              set_exl;
        logic              clr_exl;
        logic              clr_erl;
    } cp0_upd_t;

    // Refill shares the TLBL cause code; ERET leaves Cause untouched (code 0).
    function automatic logic [EXCT_W-1:0] exccode_of(input logic [EXCT_W-1:0] t);
        case (t)
            EXCT_TLBR: exccode_of = 5'd2;
            EXCT_ERET: exccode_of = 5'd0;
            default:   exccode_of = t;
        endcase
    endfunction

    function automatic logic needs_bva(input logic [EXCT_W-1:0] t);
        needs_bva = (t == EXCT_ADE) || (t == EXCT_TLBR) ||
                    (t == EXCT_TLBI) || (t == EXCT_TLBM);
    endfunction

endpackage

// File: rtl/exc_vector_calc.sv
// Combinational mapping of latched exception + CP0 status to the redirect
// target and the field values of the atomic CP0 update.
module exc_vector_calc
    import exc_sequencer_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_BASE  = 32'hBFC0_0200,
    parameter logic [XLEN-1:0] NORMAL_BASE = 32'h8000_0000
) (
    input  logic [EXCT_W-1:0] exc_type,
    input  logic [XLEN-1:0]   exc_pc,
    input  logic [XLEN-1:0]   exc_baddr,
    input  logic              exc_bd,
    input  logic              st_exl,
    input  logic              st_erl,
    input  logic              st_bev,
    input  logic [XLEN-1:0]   epc,
    input  logic [XLEN-1:0]   errorepc,
    output logic [XLEN-1:0]   target_pc_c,
    output cp0_upd_t          cp0_upd_c
);

    logic [XLEN-1:0] base;
    logic [XLEN-1:0] offset;

    always_comb begin
        base        = st_bev ? RESET_BASE : NORMAL_BASE;
        offset      = ((exc_type == EXCT_TLBR) && !st_exl) ? VEC_OFF_REFILL : VEC_OFF_GENERAL;
        target_pc_c = XLEN'(base + offset);
        cp0_upd_c   = '0;

        if (exc_type == EXCT_ERET) begin
            target_pc_c       = st_erl ? errorepc : epc;
            cp0_upd_c.clr_erl = st_erl;
            cp0_upd_c.clr_exl = !st_erl;
        end else begin
            cp0_upd_c.set_exl = 1'b1;
            cp0_upd_c.exccode = exccode_of(exc_type);
            // Nested exceptions keep the original EPC and BD.
            if (!st_exl) begin
                cp0_upd_c.epc_we = 1'b1;
                cp0_upd_c.epc    = exc_bd ? XLEN'(exc_pc - 32'd4) : exc_pc;
                cp0_upd_c.bd     = exc_bd;
            end
            if (needs_bva(exc_type)) begin
                cp0_upd_c.bva_we = 1'b1;
                cp0_upd_c.bva    = exc_baddr;
            end
        end
    end

endmodule

// File: rtl/exc_sequencer.sv
// Exception sequencer: freezes the pipeline, drains memory traffic, emits one
// atomic CP0 update and redirects fetch over a valid/ready handshake.
module exc_sequencer
    import exc_sequencer_pkg::*;
#(
    parameter int unsigned     DRAIN_MAX   = 255,
    parameter logic [XLEN-1:0] RESET_BASE  = 32'hBFC0_0200,
    parameter logic [XLEN-1:0] NORMAL_BASE = 32'h8000_0000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              exc_flag,
    input  logic [EXCT_W-1:0] exc_type,
    input  logic [XLEN-1:0]   exc_pc,
    input  logic [XLEN-1:0]   exc_baddr,
    input  logic              exc_bd,
    input  logic              bus_busy,
    input  logic              st_exl,
    input  logic              st_erl,
    input  logic              st_bev,
    input  logic [XLEN-1:0]   epc,
    input  logic [XLEN-1:0]   errorepc,
    input  logic              redir_ready,
    output logic              stall,
    output logic              flush,
    output logic              cp0_we,
    output logic              cp0_epc_we,
    output logic              cp0_bva_we,
    output logic [XLEN-1:0]   cp0_epc,
    output logic [XLEN-1:0]   cp0_bva,
    output logic [EXCT_W-1:0] cp0_exccode,
    output logic              cp0_bd,
    output logic              cp0_set_exl,
    output logic              cp0_clr_exl,
    output logic              cp0_clr_erl,
    output logic              redir_valid,
    output logic [XLEN-1:0]   redir_pc,
    output logic              drain_tmo
);

    seq_state_e        state_q, state_d;
    logic [EXCT_W-1:0] type_q, type_d;
    logic [XLEN-1:0]   pc_q, pc_d;
    logic [XLEN-1:0]   baddr_q, baddr_d;
    logic              bd_q, bd_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              tmo_q, tmo_d;
    logic              cp0_we_q, cp0_we_d;
    cp0_upd_t          cp0_q, cp0_d;
    logic              redir_valid_q, redir_valid_d;
    logic [XLEN-1:0]   redir_pc_q, redir_pc_d;

    logic [XLEN-1:0]   target_pc_c;
    cp0_upd_t          cp0_upd_c;

    exc_vector_calc #(
        .RESET_BASE  (RESET_BASE),
        .NORMAL_BASE (NORMAL_BASE)
    ) u_vec (
        .exc_type    (type_q),
        .exc_pc      (pc_q),
        .exc_baddr   (baddr_q),
        .exc_bd      (bd_q),
        .st_exl      (st_exl),
        .st_erl      (st_erl),
        .st_bev      (st_bev),
        .epc         (epc),
        .errorepc    (errorepc),
        .target_pc_c (target_pc_c),
        .cp0_upd_c   (cp0_upd_c)
    );

    always_comb begin
        state_d       = state_q;
        type_d        = type_q;
        pc_d          = pc_q;
        baddr_d       = baddr_q;
        bd_d          = bd_q;
        cnt_d         = cnt_q;
        tmo_d         = tmo_q;
        cp0_we_d      = 1'b0;
        cp0_d         = '0;
        redir_valid_d = redir_valid_q;
        redir_pc_d    = redir_pc_q;

        case (state_q)
            ST_IDLE: begin
                if (exc_flag) begin
                    type_d  = exc_type;
                    pc_d    = exc_pc;
                    baddr_d = exc_baddr;
                    bd_d    = exc_bd;
                    cnt_d   = '0;
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                cnt_d = CNT_W'(cnt_q + 1'b1);
                // A drained bus wins over a simultaneous timeout.
                if (!bus_busy || (cnt_d == CNT_W'(DRAIN_MAX))) begin
                    tmo_d    = tmo_q | bus_busy;
                    state_d  = ST_COMMIT;
                    cp0_we_d = 1'b1;
                    cp0_d    = cp0_upd_c;
                end
            end
            ST_COMMIT: begin
                state_d       = ST_REDIRECT;
                redir_valid_d = 1'b1;
                redir_pc_d    = target_pc_c;
            end
            ST_REDIRECT: begin
                if (redir_ready) begin
                    redir_valid_d = 1'b0;
                    state_d       = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            type_q        <= '0;
            pc_q          <= '0;
            baddr_q       <= '0;
            bd_q          <= 1'b0;
            cnt_q         <= '0;
            tmo_q         <= 1'b0;
            cp0_we_q      <= 1'b0;
            cp0_q         <= '0;
            redir_valid_q <= 1'b0;
            redir_pc_q    <= RESET_BASE;
        end else begin
            state_q       <= state_d;
            type_q        <= type_d;
            pc_q          <= pc_d;
            baddr_q       <= baddr_d;
            bd_q          <= bd_d;
            cnt_q         <= cnt_d;
            tmo_q         <= tmo_d;
            cp0_we_q      <= cp0_we_d;
            cp0_q         <= cp0_d;
            redir_valid_q <= redir_valid_d;
            redir_pc_q    <= redir_pc_d;
        end
    end

    assign stall       = (state_q != ST_IDLE);
    assign flush       = (state_q != ST_IDLE) | exc_flag;
    assign cp0_we      = cp0_we_q;
    assign cp0_epc_we  = cp0_q.epc_we;
    assign cp0_bva_we  = cp0_q.bva_we;
    assign cp0_epc     = cp0_q.epc;
    assign cp0_bva     = cp0_q.bva;
    assign cp0_exccode = cp0_q.exccode;
    assign cp0_bd      = cp0_q.bd;
    assign cp0_set_exl = cp0_q.set_exl;
    assign cp0_clr_exl = cp0_q.clr_exl;
    assign cp0_clr_erl = cp0_q.clr_erl;
    assign redir_valid = redir_valid_q;
    assign redir_pc    = redir_pc_q;
    assign drain_tmo   = tmo_q;

endmodule

// File: tb/tb_exc_sequencer.sv
// Directed bench for exc_sequencer: table of best-case exceptions plus
// hand-written drain timeout, handshake back-pressure and reset sequences.
module tb_exc_sequencer;
    import exc_sequencer_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        exc_flag;
    logic [4:0]  exc_type;
    logic [31:0] exc_pc, exc_baddr;
    logic        exc_bd, bus_busy, st_exl, st_erl, st_bev;
    logic [31:0] epc, errorepc;
    logic        redir_ready;
    logic        stall, flush, cp0_we, cp0_epc_we, cp0_bva_we;
    logic [31:0] cp0_epc, cp0_bva;
    logic [4:0]  cp0_exccode;
    logic        cp0_bd, cp0_set_exl, cp0_clr_exl, cp0_clr_erl;
    logic        redir_valid;
    logic [31:0] redir_pc;
    logic        drain_tmo;

    int checks = 0;
    int errors = 0;
    logic proto_viol = 1'b0;

    always #5 clk = ~clk;

    exc_sequencer #(.DRAIN_MAX(4)) dut (
        .clk(clk), .rst(rst), .exc_flag(exc_flag), .exc_type(exc_type),
        .exc_pc(exc_pc), .exc_baddr(exc_baddr), .exc_bd(exc_bd),
        .bus_busy(bus_busy), .st_exl(st_exl), .st_erl(st_erl), .st_bev(st_bev),
        .epc(epc), .errorepc(errorepc), .redir_ready(redir_ready),
        .stall(stall), .flush(flush), .cp0_we(cp0_we), .cp0_epc_we(cp0_epc_we),
        .cp0_bva_we(cp0_bva_we), .cp0_epc(cp0_epc), .cp0_bva(cp0_bva),
        .cp0_exccode(cp0_exccode), .cp0_bd(cp0_bd), .cp0_set_exl(cp0_set_exl),
        .cp0_clr_exl(cp0_clr_exl), .cp0_clr_erl(cp0_clr_erl),
        .redir_valid(redir_valid), .redir_pc(redir_pc), .drain_tmo(drain_tmo)
    );

    // A new exception while the pipeline is frozen is a protocol violation.
    always @(posedge clk) begin
        if (!rst && exc_flag && stall) proto_viol <= 1'b1;
    end

    typedef struct {
        logic [4:0]  typ;
        logic [31:0] pc, baddr;
        logic        bd, bev, exl, erl;
        logic [31:0] epc, errorepc;
        logic        x_epc_we;
        logic [31:0] x_epc;
        logic        x_bva_we;
        logic [31:0] x_bva;
        logic [4:0]  x_code;
        logic        x_bd, x_set_exl, x_clr_exl, x_clr_erl;
        logic [31:0] x_redir;
    } vec_t;

    vec_t vecs[8];

    function automatic vec_t mk(
        input logic [4:0] typ, input logic [31:0] pc, baddr,
        input logic bd, bev, exl, erl, input logic [31:0] e, ee,
        input logic xew, input logic [31:0] xe, input logic xbw, input logic [31:0] xb,
        input logic [4:0] xc, input logic xbd, xs, xce, xcr, input logic [31:0] xr);
        vec_t v;
        v.typ = typ; v.pc = pc; v.baddr = baddr; v.bd = bd; v.bev = bev;
        v.exl = exl; v.erl = erl; v.epc = e; v.errorepc = ee;
        v.x_epc_we = xew; v.x_epc = xe; v.x_bva_we = xbw; v.x_bva = xb;
        v.x_code = xc; v.x_bd = xbd; v.x_set_exl = xs; v.x_clr_exl = xce;
        v.x_clr_erl = xcr; v.x_redir = xr;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic apply_status(input vec_t v);
        exc_type = v.typ; exc_pc = v.pc; exc_baddr = v.baddr; exc_bd = v.bd;
        st_bev = v.bev; st_exl = v.exl; st_erl = v.erl;
        epc = v.epc; errorepc = v.errorepc;
    endtask

    // Best case: flag at N0, DRAIN N1, COMMIT N2, REDIRECT N3, IDLE N4.
    task automatic run_best(input vec_t v, input string tag);
        apply_status(v);
        exc_flag = 1'b1;
        #1;
        chk({tag, " flush_on_flag"}, 32'(flush), 32'd1);
        tick();
        exc_flag = 1'b0;
        chk({tag, " stall_drain"}, 32'(stall), 32'd1);
        chk({tag, " we_drain"}, 32'(cp0_we), 32'd0);
        tick();
        chk({tag, " cp0_we"}, 32'(cp0_we), 32'd1);
        chk({tag, " epc_we"}, 32'(cp0_epc_we), 32'(v.x_epc_we));
        chk({tag, " epc"}, cp0_epc, v.x_epc);
        chk({tag, " bva_we"}, 32'(cp0_bva_we), 32'(v.x_bva_we));
        chk({tag, " bva"}, cp0_bva, v.x_bva);
        chk({tag, " exccode"}, 32'(cp0_exccode), 32'(v.x_code));
        chk({tag, " bd"}, 32'(cp0_bd), 32'(v.x_bd));
        chk({tag, " set_exl"}, 32'(cp0_set_exl), 32'(v.x_set_exl));
        chk({tag, " clr_exl"}, 32'(cp0_clr_exl), 32'(v.x_clr_exl));
        chk({tag, " clr_erl"}, 32'(cp0_clr_erl), 32'(v.x_clr_erl));
        tick();
        chk({tag, " redir_valid"}, 32'(redir_valid), 32'd1);
        chk({tag, " redir_pc"}, redir_pc, v.x_redir);
        chk({tag, " we_after"}, 32'(cp0_we), 32'd0);
        tick();
        chk({tag, " idle_stall"}, 32'(stall), 32'd0);
        chk({tag, " idle_valid"}, 32'(redir_valid), 32'd0);
    endtask

    // Runs a DRAIN phase with bus_busy high; optionally drops it in DRAIN cycle 4.
    task automatic drain_busy(input bit drop_at_4, output int n);
        bus_busy = 1'b1;
        exc_flag = 1'b1;
        n = 0;
        tick();
        exc_flag = 1'b0;
        while (!cp0_we && n < 20) begin
            n++;
            if (drop_at_4 && n == 4) bus_busy = 1'b0;
            tick();
        end
        bus_busy = 1'b0;
    endtask

    initial begin
        int n;
        vecs[0] = mk(EXCT_SYS,  32'h8000_1000, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0,
                     1'b1, 32'h8000_1000, 1'b0, 32'h0, 5'd8, 1'b0, 1'b1, 1'b0, 1'b0, 32'h8000_0180);
        vecs[1] = mk(EXCT_TLBR, 32'h8000_2004, 32'h0040_0000, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0,
                     1'b1, 32'h8000_2000, 1'b1, 32'h0040_0000, 5'd2, 1'b1, 1'b1, 1'b0, 1'b0, 32'h8000_0000);
        vecs[2] = mk(EXCT_ADE,  32'h8000_3000, 32'h0000_0003, 1'b1, 1'b1, 1'b1, 1'b0, 32'h0, 32'h0,
                     1'b0, 32'h0, 1'b1, 32'h0000_0003, 5'd4, 1'b0, 1'b1, 1'b0, 1'b0, 32'hBFC0_0380);
        vecs[3] = mk(EXCT_ERET, 32'h8000_0500, 32'h0, 1'b0, 1'b1, 1'b1, 1'b1, 32'h8000_4000, 32'hBFC0_0010,
                     1'b0, 32'h0, 1'b0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 32'hBFC0_0010);
        vecs[4] = mk(EXCT_ERET, 32'h8000_0600, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h8000_4000, 32'hBFC0_0010,
                     1'b0, 32'h0, 1'b0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h8000_4000);
        vecs[5] = mk(EXCT_TLBR, 32'h8000_0700, 32'h1234_5000, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 32'h0,
                     1'b0, 32'h0, 1'b1, 32'h1234_5000, 5'd2, 1'b0, 1'b1, 1'b0, 1'b0, 32'h8000_0180);
        vecs[6] = mk(EXCT_TLBI, 32'h8000_5000, 32'hDEAD_B000, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0,
                     1'b1, 32'h8000_5000, 1'b1, 32'hDEAD_B000, 5'd2, 1'b0, 1'b1, 1'b0, 1'b0, 32'hBFC0_0380);
        vecs[7] = mk(EXCT_TLBM, 32'h8000_6008, 32'h0000_7FFC, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0,
                     1'b1, 32'h8000_6004, 1'b1, 32'h0000_7FFC, 5'd1, 1'b1, 1'b1, 1'b0, 1'b0, 32'h8000_0180);

        rst = 1'b1; exc_flag = 1'b0; bus_busy = 1'b0; redir_ready = 1'b1;
        apply_status(vecs[0]);
        tick(); tick();
        chk("rst stall", 32'(stall), 32'd0);
        chk("rst flush", 32'(flush), 32'd0);
        chk("rst cp0_we", 32'(cp0_we), 32'd0);
        chk("rst redir_valid", 32'(redir_valid), 32'd0);
        chk("rst redir_pc", redir_pc, 32'hBFC0_0200);
        chk("rst drain_tmo", 32'(drain_tmo), 32'd0);
        rst = 1'b0;
        tick();

        for (int i = 0; i < 8; i++) run_best(vecs[i], $sformatf("vec%0d", i));

        // Back-to-back: flag in the first IDLE cycle is taken on that edge.
        apply_status(vecs[0]);
        exc_flag = 1'b1;
        tick();
        chk("b2b stall", 32'(stall), 32'd1);
        exc_flag = 1'b0;
        tick(); tick(); tick();
        chk("b2b idle", 32'(stall), 32'd0);

        // Bus drains on the same edge the counter hits DRAIN_MAX: normal exit.
        apply_status(vecs[0]);
        drain_busy(1'b1, n);
        chk("edge drain_cycles", 32'(n), 32'd4);
        chk("edge drain_tmo", 32'(drain_tmo), 32'd0);
        tick(); tick();
        chk("edge idle", 32'(stall), 32'd0);

        // Timeout with redirect back-pressure.
        apply_status(vecs[0]);
        redir_ready = 1'b0;
        drain_busy(1'b0, n);
        chk("tmo drain_cycles", 32'(n), 32'd4);
        chk("tmo cp0_we", 32'(cp0_we), 32'd1);
        chk("tmo epc", cp0_epc, 32'h8000_1000);
        chk("tmo drain_tmo", 32'(drain_tmo), 32'd1);
        tick();
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("bp valid%0d", k), 32'(redir_valid), 32'd1);
            chk($sformatf("bp pc%0d", k), redir_pc, 32'h8000_0180);
            chk($sformatf("bp we%0d", k), 32'(cp0_we), 32'd0);
            tick();
        end
        redir_ready = 1'b1;
        chk("bp valid_last", 32'(redir_valid), 32'd1);
        tick();
        chk("bp idle", 32'(redir_valid), 32'd0);
        run_best(vecs[1], "sticky");
        chk("sticky drain_tmo", 32'(drain_tmo), 32'd1);

        // Reset while waiting in REDIRECT.
        apply_status(vecs[6]);
        redir_ready = 1'b0;
        exc_flag = 1'b1;
        tick();
        exc_flag = 1'b0;
        tick(); tick();
        chk("rr in_redirect", 32'(redir_valid), 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rr stall", 32'(stall), 32'd0);
        chk("rr redir_valid", 32'(redir_valid), 32'd0);
        chk("rr redir_pc", redir_pc, 32'hBFC0_0200);
        chk("rr cp0_we", 32'(cp0_we), 32'd0);
        chk("rr set_exl", 32'(cp0_set_exl), 32'd0);
        chk("rr drain_tmo", 32'(drain_tmo), 32'd0);
        tick();
        chk("rr post cp0_we", 32'(cp0_we), 32'd0);
        chk("rr post stall", 32'(stall), 32'd0);
        redir_ready = 1'b1;

        chk("protocol exc_flag while frozen", 32'(proto_viol), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

endmodule
